multi_tap_delay: RTL and testbench
==================================

Name: multi_tap_delay

Overview:
- Parametrised successor to the single-offset audio delay. One circular sample RAM is shared by N_TAPS independently delayed read taps.
- Each accepted input sample is written once. Every tap is then read sequentially from the same RAM, and the enabled tap values are summed into one echo/comb output with a valid strobe.
- Sits between the sample source (mic/sinegen path) and the output DAC/plot stage. Supports multi-echo effects with fixed, predictable latency.

Parameters:
- A_WIDTH, 9, RAM address width; depth = 2^A_WIDTH samples; max tap delay = 2^A_WIDTH-1.
- D_WIDTH, 8, unsigned sample width.
- N_TAPS, 4, number of read taps (>=1).
- S_WIDTH, D_WIDTH+$clog2(N_TAPS+1), output sum width (derived; do not override).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  sample strobe; accepted only when busy=0
- in_sample  input  D_WIDTH  unsigned input sample
- tap_delay  input  N_TAPS*A_WIDTH  packed delays; tap k at bits [k*A_WIDTH +: A_WIDTH]
- tap_en  input  N_TAPS  per-tap enable
- busy  output  1  high while a sample is being processed
- out_valid  output  1  one-cycle pulse when out_sample is updated
- out_sample  output  S_WIDTH  sum of enabled, filled taps

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE; busy=0, out_valid=0, out_sample=0.
  - Write pointer wptr=0, fill count fcnt=0, accumulator=0.
  - RAM contents are not cleared; the fill logic below masks stale data.
- States:
  - IDLE: busy=0.
  - READ: issues tap reads; busy=1.
  - DRAIN: collects the last read; busy=1.
- Accept edge E0 (IDLE and in_valid=1):
  - Write in_sample to RAM[wptr].
  - Latch tap_delay, tap_en and the snapshot fcnt_s = min(fcnt+1, 2^A_WIDTH).
  - Clear accumulator; tap index=0; go to READ.
  - Then wptr <= wptr+1 (wraps modulo 2^A_WIDTH) and fcnt saturates at 2^A_WIDTH (A_WIDTH+1 bits).
- READ, edges E0+1 .. E0+N_TAPS:
  - Issue read address rad_k = wptr_at_accept - delay_k, modulo 2^A_WIDTH (natural wrap), for k = 0..N_TAPS-1.
  - The RAM has a synchronous read with 1-cycle latency.
  - After the last issue, go to DRAIN.
- Accumulate:
  - Data for tap k arrives one edge after its issue.
  - Accumulator += data if tap_en_k=1 and delay_k < fcnt_s; otherwise += 0.
  - Disabled and unfilled taps still consume their slot, so latency is fixed.
- DRAIN, edge E0+N_TAPS+1:
  - out_sample <= final sum; out_valid=1 for exactly that cycle; go to IDLE; busy=0 in the same cycle.
  - Latency: accept edge to out_valid is N_TAPS+1 clocks.
  - Maximum throughput is one sample per N_TAPS+2 clocks.
- in_valid while busy=1: ignored, not queued; no state change.
- out_sample holds its value between pulses.
- Delay 0 returns the current sample, because the write at E0 precedes all reads.
- Delay d is valid only once d+1 samples have been accepted since reset; before that the tap contributes 0.
- The sum cannot overflow: S_WIDTH bits hold N_TAPS*(2^D_WIDTH-1).
- tap_delay/tap_en changes mid-operation have no effect until the next accept.
- rst mid-operation: in-flight sample dropped, no out_valid pulse, all state returns to reset values; the next accept writes address 0.

Test Plan:
- Reset, then in_valid with in_sample=100, all taps delay 0 and enabled → out_valid pulse exactly 5 clocks after accept; out_sample=400; busy high for those 5 cycles.
- Feed samples 1,2,3,... back-to-back; delays {0,1,2,3}, all enabled → after the 4th sample, out=4+3+2+1=10; for the 2nd sample, out=2+1=3 (taps 2 and 3 masked as unfilled).
- tap_en=4'b0101, delays {0,5,10,20}, steady input 50 after 30 samples → out=100; tap_en=0 → out=0 with a pulse still present.
- Wrap: with A_WIDTH=9, feed 600 incrementing samples (values mod 256), delay 511 on tap0 only → output equals the sample 511 earlier; verify across the wptr 511→0 wrap.
- Assert in_valid every cycle → accepts only every 6th cycle; ignored samples never appear in the output.
- Assert rst two cycles after an accept → no out_valid pulse; the next sample with delay 1 yields 0 (fcnt cleared).

Source files
------------

// File: rtl/multi_tap_delay.sv
// Multi-tap delay line: one circular sample RAM, N_TAPS independently
// delayed read taps. Each accepted sample is written once, then all taps
// are read in sequence and the enabled, filled taps are summed.
module multi_tap_delay #(
  parameter int unsigned A_WIDTH = 9,
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned N_TAPS  = 4,
  parameter int unsigned S_WIDTH = D_WIDTH + $clog2(N_TAPS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [D_WIDTH-1:0]          in_sample,
  input  logic [N_TAPS*A_WIDTH-1:0]   tap_delay,
  input  logic [N_TAPS-1:0]           tap_en,
  output logic                        busy,
  output logic                        out_valid,
  output logic [S_WIDTH-1:0]          out_sample
);

  localparam int unsigned Depth = 2 ** A_WIDTH;
  localparam int unsigned IW    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [IW-1:0]    LastIdx = IW'(N_TAPS - 1);
  localparam logic [A_WIDTH:0] FullCnt = {1'b1, {A_WIDTH{1'b0}}};

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e state_q, state_d;

  logic [D_WIDTH-1:0] mem [Depth];
  logic [D_WIDTH-1:0] rdata_q;

  logic [A_WIDTH-1:0] wptr_q;
  logic [A_WIDTH-1:0] base_q;      // write address of the sample being processed
  logic [A_WIDTH:0]   fcnt_q;      // samples accepted since reset, saturating at Depth
  logic [A_WIDTH:0]   fcnt_s_q;    // fill snapshot taken at accept
  logic [A_WIDTH-1:0] dly_q [N_TAPS];
  logic [N_TAPS-1:0]  en_q;
  logic [IW-1:0]      idx_q;
  logic               take_q;      // rdata_q belongs to an enabled, filled tap
  logic [S_WIDTH-1:0] acc_q;
  logic [S_WIDTH-1:0] out_sample_q;
  logic               out_valid_q;

  logic               accept;
  logic [A_WIDTH:0]   fcnt_inc;
  logic [A_WIDTH-1:0] cur_dly;
  logic [A_WIDTH-1:0] rd_addr;
  logic               cur_take;
  logic [S_WIDTH-1:0] add_val;
  logic [S_WIDTH-1:0] sum;

  // Datapath helpers for the tap currently being issued
  always_comb begin
    accept   = (state_q == StIdle) && in_valid;
    fcnt_inc = (fcnt_q == FullCnt) ? FullCnt : fcnt_q + 1'b1;
    cur_dly  = dly_q[idx_q];
    rd_addr  = base_q - cur_dly;
    // A tap of delay d only holds real data once d+1 samples have been written
    cur_take = en_q[idx_q] && ({1'b0, cur_dly} < fcnt_s_q);
    add_val  = take_q ? S_WIDTH'(rdata_q) : '0;
    sum      = acc_q + add_val;
  end

  // Sample RAM: write on accept, synchronous read while issuing taps
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr_q] <= in_sample;
    end
    if (state_q == StRead) begin
      rdata_q <= mem[rd_addr];
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRead;
      StRead:  if (idx_q == LastIdx) state_d = StDrain;
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != StIdle);
  end

  // Pointers, tap snapshot, accumulator and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      base_q       <= '0;
      fcnt_q       <= '0;
      fcnt_s_q     <= '0;
      en_q         <= '0;
      idx_q        <= '0;
      take_q       <= 1'b0;
      acc_q        <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      for (int k = 0; k < N_TAPS; k++) begin
        dly_q[k] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            base_q   <= wptr_q;
            wptr_q   <= wptr_q + 1'b1;
            fcnt_q   <= fcnt_inc;
            fcnt_s_q <= fcnt_inc;
            en_q     <= tap_en;
            idx_q    <= '0;
            take_q   <= 1'b0;
            acc_q    <= '0;
            for (int k = 0; k < N_TAPS; k++) begin
              dly_q[k] <= tap_delay[k*A_WIDTH +: A_WIDTH];
            end
          end
        end
        StRead: begin
          acc_q  <= sum;
          take_q <= cur_take;
          idx_q  <= idx_q + 1'b1;
        end
        StDrain: begin
          out_sample_q <= sum;
          out_valid_q  <= 1'b1;
          take_q       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;

endmodule

// File: tb/tb_multi_tap_delay.sv
// Scoreboard bench for multi_tap_delay: stimulus pushes expected sums and
// due cycles, a monitor pops and compares on every out_valid pulse.
module tb_multi_tap_delay;

  localparam int A = 9;
  localparam int D = 8;
  localparam int N = 4;
  localparam int S = D + $clog2(N + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [D-1:0]   in_sample;
  logic [N*A-1:0] tap_delay;
  logic [N-1:0]   tap_en;
  logic           busy;
  logic           out_valid;
  logic [S-1:0]   out_sample;

  multi_tap_delay #(.A_WIDTH(A), .D_WIDTH(D), .N_TAPS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .tap_delay  (tap_delay),
    .tap_en     (tap_en),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_sample (out_sample)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got out_sample %0d, required no pulse", out_sample);
      end else begin
        mon_e = sb.pop_front();
        check("out_sample", int'(out_sample), mon_e.val);
        check("latency_cycle", cyc, mon_e.due);
      end
    end
  end

  function automatic logic [N*A-1:0] pack(input int d0, input int d1, input int d2, input int d3);
    logic [A-1:0] a0, a1, a2, a3;
    a0 = A'(d0);
    a1 = A'(d1);
    a2 = A'(d2);
    a3 = A'(d3);
    return {a3, a2, a1, a0};
  endfunction

  // Drive one sample once the DUT is idle; accepted on the next rising edge
  task automatic send(input int s, input int exp, input bit track);
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL busy_timeout: got busy 1, required 0");
    end
    in_valid  = 1'b1;
    in_sample = D'(s);
    if (track) sb.push_back('{exp, cyc + 6});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", sb.size(), 0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sample", int'(out_sample), 0);
  endtask

  int exp5 [4] = '{1, 8, 21, 40};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sample = '0;
    tap_delay = '0;
    tap_en    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("init_busy", int'(busy), 0);
    check("init_out_valid", int'(out_valid), 0);
    check("init_out_sample", int'(out_sample), 0);

    // All taps at delay 0: four copies of the current sample, busy for 5 cycles
    tap_delay = pack(0, 0, 0, 0);
    tap_en    = 4'b1111;
    send(100, 400, 1'b1);
    check("busy_c1", int'(busy), 1);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      check("busy_hi", int'(busy), 1);
    end
    @(negedge clk);
    check("busy_lo", int'(busy), 0);
    wait_drain();
    check("hold_out_sample", int'(out_sample), 400);

    // Incrementing samples, delays 0..3: unfilled taps masked early on
    do_reset();
    tap_delay = pack(0, 1, 2, 3);
    tap_en    = 4'b1111;
    send(1, 1, 1'b1);
    send(2, 3, 1'b1);
    send(3, 6, 1'b1);
    send(4, 10, 1'b1);
    send(5, 14, 1'b1);
    send(6, 18, 1'b1);
    wait_drain();

    // Sparse enables on a steady input; tap 2 (delay 10) fills at sample 11
    do_reset();
    tap_delay = pack(0, 5, 10, 20);
    tap_en    = 4'b0101;
    for (int n = 1; n <= 30; n++) send(50, (n <= 10) ? 50 : 100, 1'b1);
    tap_en = 4'b0000;
    send(50, 0, 1'b1);
    wait_drain();

    // Max delay across the write-pointer wrap
    do_reset();
    tap_delay = pack(511, 3, 7, 9);
    tap_en    = 4'b0001;
    for (int i = 0; i < 600; i++) send(i % 256, (i < 511) ? 0 : ((i - 511) % 256), 1'b1);
    wait_drain();

    // in_valid held high: only every 6th cycle is accepted
    do_reset();
    tap_delay = pack(0, 1, 2, 3);
    tap_en    = 4'b1111;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sample = D'(j + 1);
      if (j % 6 == 0) sb.push_back('{exp5[j / 6], cyc + 6});
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_drain();

    // Reset mid-operation drops the sample and clears the fill count
    do_reset();
    tap_delay = pack(1, 0, 0, 0);
    tap_en    = 4'b0001;
    send(77, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    send(33, 0, 1'b1);
    send(44, 33, 1'b1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
